// File: rtl/sevenseg_capture.sv
// Reconstructs the 16-bit hex value and dp bits from multiplexed seven-segment pins.
// Optional: define SEVENSEG_CAPTURE_CHANGE_EN to pulse frame only when the captured value changes.
module sevenseg_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  SSEG_AN,
  input  logic [7:0]  SSEG_CA,
  output logic [15:0] dout,
  output logic [3:0]  dpout,
  output logic        valid,
  output logic        frame,
  output logic        err
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    an_m, an_s;
  logic [7:0]    ca_m, ca_s;
  logic [11:0]   pins_q;
  logic [CW-1:0] count;
  logic          captured;
  logic [TW-1:0] tcount;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [3:0]    seen;

  logic          change, sample, one_low, any_low, glyph_ok, capture, reject, complete;
  logic [3:0]    an_low, nibble, seen_m, dp_m;
  logic [1:0]    idx;
  logic [15:0]   shadow_m;

  // Matches the 16 standard hex glyphs (segments g..a, low-true); bit 4 flags a match
  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: hex_decode = 5'h10;
      7'b1111001: hex_decode = 5'h11;
      7'b0100100: hex_decode = 5'h12;
      7'b0110000: hex_decode = 5'h13;
      7'b0011001: hex_decode = 5'h14;
      7'b0010010: hex_decode = 5'h15;
      7'b0000010: hex_decode = 5'h16;
      7'b1111000: hex_decode = 5'h17;
      7'b0000000: hex_decode = 5'h18;
      7'b0010000: hex_decode = 5'h19;
      7'b0001000: hex_decode = 5'h1A;
      7'b0000011: hex_decode = 5'h1B;
      7'b1000110: hex_decode = 5'h1C;
      7'b0100001: hex_decode = 5'h1D;
      7'b0000110: hex_decode = 5'h1E;
      7'b0001110: hex_decode = 5'h1F;
      default:    hex_decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    change   = ({an_s, ca_s} != pins_q);
    sample   = !change && (count == CMAX) && !captured;
    an_low   = ~an_s;
    any_low  = (an_low != 4'b0000);
    one_low  = any_low && ((an_low & (an_low - 4'd1)) == 4'b0000);
    {glyph_ok, nibble} = hex_decode(ca_s[6:0]);
    idx = 2'd0;
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    capture  = sample && one_low && glyph_ok;
    reject   = sample && any_low && !(one_low && glyph_ok);
    shadow_m = shadow;
    dp_m     = shadow_dp;
    seen_m   = seen;
    if (capture) begin
      shadow_m[{idx, 2'b00} +: 4] = nibble;
      dp_m[idx]   = ca_s[7];
      seen_m[idx] = 1'b1;
    end
    complete = capture && (seen_m == 4'b1111);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_m      <= 4'hF;
      an_s      <= 4'hF;
      ca_m      <= 8'hFF;
      ca_s      <= 8'hFF;
      pins_q    <= 12'hFFF;
      count     <= '0;
      captured  <= 1'b0;
      tcount    <= '0;
      shadow    <= 16'h0;
      shadow_dp <= 4'h0;
      seen      <= 4'h0;
      dout      <= 16'h0;
      dpout     <= 4'h0;
      valid     <= 1'b0;
      frame     <= 1'b0;
      err       <= 1'b0;
    end else begin
      an_m   <= SSEG_AN;
      an_s   <= an_m;
      ca_m   <= SSEG_CA;
      ca_s   <= ca_m;
      pins_q <= {an_s, ca_s};
      err    <= reject;
      frame  <= 1'b0;
      if (change) begin
        count    <= '0;
        captured <= 1'b0;
      end else begin
        if (count != CMAX) count <= count + 1'b1;
        if (sample) captured <= 1'b1;
      end
      // A capture always beats a timeout in the same cycle
      if (capture) begin
        shadow    <= shadow_m;
        shadow_dp <= dp_m;
        tcount    <= '0;
        if (complete) begin
          dout  <= shadow_m;
          dpout <= dp_m;
          valid <= 1'b1;
          seen  <= 4'h0;
`ifdef SEVENSEG_CAPTURE_CHANGE_EN
          frame <= ({shadow_m, dp_m} != {dout, dpout});
`else
          frame <= 1'b1;
`endif
        end else begin
          seen <= seen_m;
        end
      end else if (tcount == TMAX) begin
        valid <= 1'b0;
        seen  <= 4'h0;
      end else begin
        tcount <= tcount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: vector table plus timeout, reset and repeat-frame sequences.
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  ca = 8'hFF;
  logic [15:0] dout;
  logic [3:0]  dpout;
  logic        valid, frame, err;

  int checks = 0;
  int failures = 0;
  int fcnt = 0;
  int ecnt = 0;

  localparam logic [7:0] G0 = 8'b1_1000000;
  localparam logic [7:0] G1 = 8'b1_1111001;
  localparam logic [7:0] G2 = 8'b0_0100100;
  localparam logic [7:0] G3 = 8'b0_0110000;

`ifdef SEVENSEG_CAPTURE_CHANGE_EN
  localparam int SAME_FRAMES = 0;
`else
  localparam int SAME_FRAMES = 1;
`endif

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  ca;
    int          hold;
    int          frames;
    int          errs;
    logic [15:0] dout;
    logic [3:0]  dp;
    logic        valid;
  } vec_t;

  vec_t vecs[17];

  sevenseg_capture #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .SSEG_AN(an), .SSEG_CA(ca),
    .dout(dout), .dpout(dpout), .valid(valid), .frame(frame), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (frame) fcnt++;
    if (err) ecnt++;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] c, input int hold);
    an = a;
    ca = c;
    repeat (hold) stepCycle();
  endtask

  task automatic sendFrame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    applyStimulus(4'b1110, c0, 20);
    applyStimulus(4'b1101, c1, 20);
    applyStimulus(4'b1011, c2, 20);
    applyStimulus(4'b0111, c3, 20);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    // Full frame, then glitch rejection, then bad glyph / illegal anode
    vecs[0]  = '{4'b1110, G0, 20, 0, 0, 16'h0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1101, G1, 20, 0, 0, 16'h0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1011, G2, 20, 0, 0, 16'h0000, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0111, G3, 20, 1, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[4]  = '{4'b1110, 8'b1_0001110, 10, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[5]  = '{4'b1110, G0, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[6]  = '{4'b1101, G1, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[7]  = '{4'b1011, G2, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[8]  = '{4'b0111, 8'b0_0001110, 10, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[9]  = '{4'b0111, G3, 20, SAME_FRAMES, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[10] = '{4'b1110, 8'b1_0010010, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[11] = '{4'b1011, 8'b1_1111000, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[12] = '{4'b0111, 8'b0_0000000, 20, 0, 0, 16'h3210, 4'b0011, 1'b1};
    vecs[13] = '{4'b1101, 8'hFF, 20, 0, 1, 16'h3210, 4'b0011, 1'b1};
    vecs[14] = '{4'b1100, 8'hFF, 20, 0, 1, 16'h3210, 4'b0011, 1'b1};
    vecs[15] = '{4'b1101, 8'b0_0000010, 20, 1, 0, 16'h8765, 4'b0101, 1'b1};
    vecs[16] = '{4'b1111, 8'hFF, 20, 0, 0, 16'h8765, 4'b0101, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) stepCycle();
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_dpout", 32'(dpout), 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_frame", 32'(frame), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);

    for (int i = 0; i < 17; i++) begin
      fcnt = 0;
      ecnt = 0;
      applyStimulus(vecs[i].an, vecs[i].ca, vecs[i].hold);
      checkOutput($sformatf("vec%0d_frames", i), 32'(fcnt), 32'(vecs[i].frames));
      checkOutput($sformatf("vec%0d_errs", i), 32'(ecnt), 32'(vecs[i].errs));
      checkOutput($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].dout));
      checkOutput($sformatf("vec%0d_dpout", i), 32'(dpout), 32'(vecs[i].dp));
      checkOutput($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
    end

    // Timeout: valid drops exactly 200 clocks after the completing capture
    begin
      bit found = 1'b0;
      fcnt = 0;
      applyStimulus(4'b1110, G0, 20);
      applyStimulus(4'b1101, G1, 20);
      applyStimulus(4'b1011, G2, 20);
      an = 4'b0111;
      ca = G3;
      for (int k = 0; k < 40 && !found; k++) begin
        stepCycle();
        if (fcnt != 0) found = 1'b1;
      end
      checkOutput("timeout_frame_seen", 32'(found), 32'h1);
      an = 4'hF;
      ca = 8'hFF;
      repeat (199) stepCycle();
      checkOutput("timeout_valid_before", 32'(valid), 32'h1);
      stepCycle();
      checkOutput("timeout_valid_after", 32'(valid), 32'h0);
      checkOutput("timeout_dout_held", 32'(dout), 32'h3210);
      checkOutput("timeout_dpout_held", 32'(dpout), 32'h3);
    end

    // Reset mid-frame discards the partial frame
    fcnt = 0;
    applyStimulus(4'b1110, G0, 20);
    applyStimulus(4'b1101, G1, 20);
    applyStimulus(4'hF, 8'hFF, 5);
    pulseReset();
    checkOutput("midreset_dout", 32'(dout), 32'h0);
    applyStimulus(4'b1011, G2, 20);
    applyStimulus(4'b0111, G3, 20);
    applyStimulus(4'hF, 8'hFF, 20);
    checkOutput("midreset_frames", 32'(fcnt), 32'h0);
    checkOutput("midreset_dout_after", 32'(dout), 32'h0);
    checkOutput("midreset_valid", 32'(valid), 32'h0);
    sendFrame(G0, G1, G2, G3);
    checkOutput("postreset_frames", 32'(fcnt), 32'h1);
    checkOutput("postreset_dout", 32'(dout), 32'h3210);
    checkOutput("postreset_valid", 32'(valid), 32'h1);

    // Repeated identical frame, then a changed one
    applyStimulus(4'hF, 8'hFF, 5);
    pulseReset();
    fcnt = 0;
    ecnt = 0;
    sendFrame(G0, G1, G2, G3);
    checkOutput("repeat_first_frames", 32'(fcnt), 32'h1);
    sendFrame(G0, G1, G2, G3);
    checkOutput("repeat_second_frames", 32'(fcnt), 32'(1 + SAME_FRAMES));
    sendFrame(G1, G1, G2, G3);
    checkOutput("repeat_third_frames", 32'(fcnt), 32'(2 + SAME_FRAMES));
    checkOutput("repeat_dout", 32'(dout), 32'h3211);
    checkOutput("repeat_valid", 32'(valid), 32'h1);
    checkOutput("repeat_errs", 32'(ecnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
